// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Instruction-memory read bus plus the decode valid/ready handoff.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output mem_req, mem_addr, instr_out, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_out, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage: reads memory at the PC, buffers one instruction for
//            decode and holds the PC until that instruction is handed off.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  Clock,
  input  wire logic                  Reset_n,
  input  wire logic [ADDR_WIDTH-1:0] pc_in,
  input  wire logic                  flush,
  output logic                       stall_pc,
  instruction_fetch_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_instr_out;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_instr_valid;
  logic                  w_mem_req;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_stall_pc;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_addr   = pc_in;
    w_stall_pc   = 1'b1;
    case (r_state)
      IDLE: begin
        w_next_state = ISSUE;
      end
      ISSUE: begin
        w_mem_req = 1'b1;
        if (flush && !bus.mem_ack) begin
          w_next_state = DRAIN;
        end else if (bus.mem_ack && !flush) begin
          w_next_state = HOLD;
        end
      end
      DRAIN: begin
        // The outstanding request keeps its pre-redirect address until acked.
        w_mem_req  = 1'b1;
        w_mem_addr = r_req_addr;
        if (bus.mem_ack) begin
          w_next_state = ISSUE;
        end
      end
      HOLD: begin
        if (flush) begin
          w_next_state = ISSUE;
        end else if (bus.instr_ready) begin
          w_stall_pc   = 1'b0;
          w_next_state = ISSUE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_req_addr    <= '0;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ISSUE: begin
          r_req_addr <= pc_in;
          if (bus.mem_ack && !flush) begin
            r_instr_out   <= bus.mem_rdata;
            r_instr_pc    <= pc_in;
            r_instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || bus.instr_ready) begin
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stall_pc        = w_stall_pc;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire
